// File: rtl/fft_out_reorder.sv
// fft_out_reorder
// Collects one FFT frame that arrives in bit-reversed order, then replays
// it downstream in natural bin order.
//
// Ports
//   clk          single clock, all state changes on its rising edge
//   reset        synchronous, active-high; aborts any partial frame
//   in_push      upstream sample valid (bit-reversed arrival order)
//   in_data      upstream sample {real, imag}
//   in_stall     high while the block is draining and refuses input
//   out_push     downstream sample valid
//   out_data     natural-order sample
//   out_index    natural-order bin index of out_data
//   out_last     high with bin N-1
//   out_stall    downstream back-pressure
//   frame_count  completed output frames, wraps 255 -> 0
//   overrun      sticky: in_push seen while in_stall was high
module fft_out_reorder #(
  parameter int DW     = 32,
  parameter int N_LOG2 = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_push,
  input  logic [DW-1:0]     in_data,
  output logic              in_stall,
  output logic              out_push,
  output logic [DW-1:0]     out_data,
  output logic [N_LOG2-1:0] out_index,
  output logic              out_last,
  input  logic              out_stall,
  output logic [7:0]        frame_count,
  output logic              overrun
);

  localparam int N = 1 << N_LOG2;
  localparam logic [N_LOG2-1:0] LAST_IDX = N_LOG2'(N - 1);
  // Read pointer is one bit wider so "all N samples presented" is distinct.
  localparam logic [N_LOG2:0]   RD_END   = (N_LOG2 + 1)'(N);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [N_LOG2-1:0]   wr_cnt_q, wr_cnt_d;
  logic [N_LOG2:0]     rd_ptr_q, rd_ptr_d;
  logic                out_push_q, out_push_d;
  logic [DW-1:0]       out_data_q, out_data_d;
  logic [N_LOG2-1:0]   out_index_q, out_index_d;
  logic                out_last_q, out_last_d;
  logic [7:0]          frame_count_q, frame_count_d;
  logic                overrun_q, overrun_d;

  logic [DW-1:0]       mem_q [N];
  logic                wr_en;
  logic [N_LOG2-1:0]   wr_addr;
  logic                xfer;

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v);
    logic [N_LOG2-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < N_LOG2; i++) begin
      r[i] = v[N_LOG2-1-i];
    end
    return r;
  endfunction

  always_comb begin
    state_d       = state_q;
    wr_cnt_d      = wr_cnt_q;
    rd_ptr_d      = rd_ptr_q;
    out_push_d    = out_push_q;
    out_data_d    = out_data_q;
    out_index_d   = out_index_q;
    out_last_d    = out_last_q;
    frame_count_d = frame_count_q;
    overrun_d     = overrun_q;
    wr_en         = 1'b0;
    wr_addr       = bitrev(wr_cnt_q);
    xfer          = out_push_q && !out_stall;

    unique case (state_q)
      FILL: begin
        if (in_push) begin
          wr_en    = 1'b1;
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == LAST_IDX) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (in_push) begin
          overrun_d = 1'b1;
        end
        if (xfer && out_last_q) begin
          out_push_d    = 1'b0;
          out_last_d    = 1'b0;
          rd_ptr_d      = '0;
          frame_count_d = frame_count_q + 8'd1;
          state_d       = FILL;
        end else if ((!out_push_q || xfer) && (rd_ptr_q != RD_END)) begin
          // Output register refills whenever it is empty or being consumed,
          // giving back-to-back bins and a hold while stalled.
          out_push_d  = 1'b1;
          out_data_d  = mem_q[rd_ptr_q[N_LOG2-1:0]];
          out_index_d = rd_ptr_q[N_LOG2-1:0];
          out_last_d  = (rd_ptr_q[N_LOG2-1:0] == LAST_IDX);
          rd_ptr_d    = rd_ptr_q + 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FILL;
      wr_cnt_q      <= '0;
      rd_ptr_q      <= '0;
      out_push_q    <= 1'b0;
      out_data_q    <= '0;
      out_index_q   <= '0;
      out_last_q    <= 1'b0;
      frame_count_q <= '0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      out_push_q    <= out_push_d;
      out_data_q    <= out_data_d;
      out_index_q   <= out_index_d;
      out_last_q    <= out_last_d;
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
    end
  end

  // Sample storage is not cleared; readout only follows a complete fill.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem_q[wr_addr] <= in_data;
    end
  end

  assign in_stall    = (state_q == DRAIN);
  assign out_push    = out_push_q;
  assign out_data    = out_data_q;
  assign out_index   = out_index_q;
  assign out_last    = out_last_q;
  assign frame_count = frame_count_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder
// Self-checking bench for fft_out_reorder: a frame-level model collects
// accepted samples, builds the natural-order frame, and predicts the
// handshake timeline; one negedge process compares every cycle.
module tb_fft_out_reorder;

  logic        clk;
  logic        reset;
  logic        in_push;
  logic [31:0] in_data;
  logic        in_stall;
  logic        out_push;
  logic [31:0] out_data;
  logic [3:0]  out_index;
  logic        out_last;
  logic        out_stall;
  logic [7:0]  frame_count;
  logic        overrun;

  fft_out_reorder #(
    .DW     (32),
    .N_LOG2 (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_push     (in_push),
    .in_data     (in_data),
    .in_stall    (in_stall),
    .out_push    (out_push),
    .out_data    (out_data),
    .out_index   (out_index),
    .out_last    (out_last),
    .out_stall   (out_stall),
    .frame_count (frame_count),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: expectations for the current cycle
  logic [31:0] acc[$];
  logic [31:0] frame [16];
  logic        e_stall = 1'b0;
  logic        e_push  = 1'b0;
  int          e_idx   = 0;
  logic [7:0]  e_fc    = 8'd0;
  logic        e_ovr   = 1'b0;
  logic        start_next = 1'b0;
  int          tot_frames = 0;
  logic        rst_prev = 1'b0;

  // controls from the stimulus process
  logic        started   = 1'b0;
  logic        dir_mode  = 1'b0;
  logic        lit_fc_en = 1'b0;
  logic [7:0]  lit_fc    = 8'd0;

  function automatic int brev(input int x);
    int r;
    r = 0;
    for (int b = 0; b < 4; b++) r = r * 2 + ((x >> b) & 1);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic cur_stall;
    if (started) begin
      chk("in_stall", 32'(in_stall), 32'(e_stall));
      chk("out_push", 32'(out_push), 32'(e_push));
      chk("frame_count", 32'(frame_count), 32'(e_fc));
      chk("overrun", 32'(overrun), 32'(e_ovr));
      if (e_push) begin
        chk("out_index", 32'(out_index), 32'(e_idx));
        chk("out_data", out_data, frame[e_idx]);
        chk("out_last", 32'(out_last), 32'(e_idx == 15));
        if (dir_mode) chk("dir_data", out_data, 32'(e_idx));
      end else begin
        chk("out_last_idle", 32'(out_last), 32'd0);
      end
      if (rst_prev) begin
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_index", 32'(out_index), 32'd0);
      end
      if (lit_fc_en) chk("lit_frame_count", 32'(frame_count), 32'(lit_fc));
    end

    // advance model to next cycle
    if (reset) begin
      acc.delete();
      e_stall = 1'b0; e_push = 1'b0; e_idx = 0; e_fc = 8'd0;
      e_ovr = 1'b0; start_next = 1'b0;
    end else begin
      cur_stall = e_stall;
      if (in_push && cur_stall) e_ovr = 1'b1;
      if (start_next) begin
        e_push = 1'b1; e_idx = 0; start_next = 1'b0;
      end else if (e_push && !out_stall) begin
        if (e_idx == 15) begin
          e_push = 1'b0; e_stall = 1'b0; e_fc = e_fc + 8'd1; tot_frames++;
        end else begin
          e_idx++;
        end
      end
      if (in_push && !cur_stall) begin
        acc.push_back(in_data);
        if (acc.size() == 16) begin
          for (int k = 0; k < 16; k++) frame[k] = acc[brev(k)];
          acc.delete();
          e_stall = 1'b1;
          start_next = 1'b1;
        end
      end
    end
    rst_prev = reset;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dir_frame();
    for (int i = 0; i < 16; i++) begin
      in_push = 1'b1;
      in_data = 32'(brev(i));
      cyc();
    end
    in_push = 1'b0;
  endtask

  task automatic lit_check_fc(input logic [7:0] v);
    lit_fc = v;
    lit_fc_en = 1'b1;
    cyc();
    lit_fc_en = 1'b0;
  endtask

  initial begin
    int base;
    int guard;
    logic done5;
    reset = 1'b1; in_push = 1'b0; out_stall = 1'b0; in_data = '0;
    cyc(); cyc();
    started = 1'b1;
    cyc();
    reset = 1'b0;

    // natural-order readout of a bit-reversed frame
    dir_mode = 1'b1;
    push_dir_frame();
    repeat (36) cyc();
    lit_check_fc(8'd1);

    // downstream stall on bin 5
    push_dir_frame();
    done5 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!done5 && out_push && out_index == 4'd5) begin
        out_stall = 1'b1;
        repeat (3) cyc();
        out_stall = 1'b0;
        done5 = 1'b1;
      end else begin
        cyc();
      end
    end
    lit_check_fc(8'd2);
    dir_mode = 1'b0;

    // pushing through a drain: ignored, overrun sticks
    in_push = 1'b1;
    for (int c = 0; c < 40; c++) begin
      in_data = $urandom;
      cyc();
    end
    in_push = 1'b0;
    repeat (10) cyc();

    // reset after 9 accepted inputs, then a clean frame
    reset = 1'b1; cyc(); reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_push = 1'b1; in_data = $urandom; cyc();
    end
    in_push = 1'b0;
    reset = 1'b1; cyc(); reset = 1'b0;
    dir_mode = 1'b1;
    push_dir_frame();
    repeat (36) cyc();
    lit_check_fc(8'd1);
    dir_mode = 1'b0;

    // 257 back-to-back frames
    reset = 1'b1; cyc(); reset = 1'b0;
    base = tot_frames;
    guard = 0;
    in_push = 1'b1;
    while (tot_frames - base < 257) begin
      in_data = $urandom;
      cyc();
      guard++;
      if (guard > 12000) begin
        $display("FAIL stream_timeout: got %0d frames, required 257", tot_frames - base);
        $fatal(1);
      end
    end
    in_push = 1'b0;
    lit_check_fc(8'd1);

    // randomized traffic with occasional resets
    for (int c = 0; c < 4000; c++) begin
      in_push   = ($urandom_range(0, 9) < 7);
      out_stall = ($urandom_range(0, 9) < 3);
      in_data   = $urandom;
      reset     = ($urandom_range(0, 499) == 0);
      cyc();
    end
    reset = 1'b0; in_push = 1'b0; out_stall = 1'b0;
    repeat (40) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_out_reorder.md
FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

Interface
REQ-001 Parameter DW, 32, sample width; packed {real[DW/2-1:0], imag[DW/2-1:0]}.
REQ-002 Parameter N_LOG2, 4, log2 of frame length (N = 16).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_push  input  1  upstream sample valid (FFT result, bit-reversed order).
REQ-006 in_data  input  DW  upstream sample.
REQ-007 in_stall  output  1  high = block refuses input.
REQ-008 out_push  output  1  downstream sample valid.
REQ-009 out_data  output  DW  natural-order sample.
REQ-010 out_index  output  N_LOG2  natural-order bin index of out_data.
REQ-011 out_last  output  1  high with bin N-1.
REQ-012 out_stall  input  1  downstream back-pressure.
REQ-013 frame_count  output  8  completed output frames, wraps 255->0.
REQ-014 overrun  output  1  sticky: in_push seen while in_stall high.

Function
REQ-015 Block SHALL hold an N x DW buffer and a state machine with states FILL and DRAIN.
REQ-016 in_stall SHALL equal 1 exactly when state is DRAIN.
REQ-017 FILL: an accepted input (in_push && !in_stall) SHALL write in_data to buf[bitrev(wr_cnt)] and increment wr_cnt (N_LOG2 bits).
REQ-018 bitrev SHALL reverse the N_LOG2 bits of wr_cnt (4-bit: 1->8, 3->12, 6->6).
REQ-019 When the accepted input has wr_cnt = N-1, wr_cnt SHALL wrap to 0 and state SHALL become DRAIN on the next edge; in_push without acceptance SHALL not advance wr_cnt.
REQ-020 Last input accepted at cycle T: in_stall high from T+1; out_push SHALL first assert at T+2 with out_data = buf[0], out_index = 0.
REQ-021 Transfer SHALL occur on any cycle with out_push && !out_stall.
REQ-022 While out_push && out_stall, out_push, out_data, out_index, out_last SHALL hold unchanged.
REQ-023 After a transfer of index k < N-1, the next cycle SHALL present buf[k+1], index k+1, out_push high (no bubble).
REQ-024 out_last SHALL be high iff out_push high and out_index = N-1.
REQ-025 Transfer of index N-1 SHALL: increment frame_count (modulo 256), drop out_push next cycle, return state to FILL next cycle (in_stall low that cycle).
REQ-026 in_push while in_stall high SHALL be ignored (no write, no count) and SHALL set overrun, which stays set until reset.
REQ-027 Outputs SHALL be registered; out_data SHALL not change combinationally with in_data or out_stall.
REQ-028 out_stall while out_push low SHALL have no effect.
REQ-029 Sample data SHALL pass bit-exact; no arithmetic on data.

Reset
REQ-030 On reset: state FILL, wr_cnt 0, read pointer 0, in_stall 0, out_push 0, out_data 0, out_index 0, out_last 0, frame_count 0, overrun 0.
REQ-031 Reset mid-FILL or mid-DRAIN SHALL abort the frame; partial data discarded, no frame_count increment.
REQ-032 Buffer contents need not be cleared by reset; no output may expose them before a full new frame is loaded.
REQ-033 Reset SHALL take priority over in_push and out_stall in the same cycle.

Verification
REQ-034 Push 16 samples data = bitrev(i) in arrival i, out_stall=0 -> out_data 0..15 in order, out_index 0..15, out_last only on 15, first out_push 2 cycles after last push, frame_count=1.
REQ-035 Same frame, out_stall high for 3 cycles when out_index=5 -> out_data/out_index held at 5 for 4 cycles, then 6..15 with no bubble.
REQ-036 in_push held high during DRAIN -> in_stall=1, overrun=1 and sticky, output frame unchanged, next FILL starts at wr_cnt 0.
REQ-037 Reset asserted after 9 accepted inputs, then a full 16-sample frame -> only the new frame is output, frame_count=1.
REQ-038 Stream 257 back-to-back frames -> frame_count reads 1 after the last, in_stall drops for one-cycle minimum between frames, no lost or duplicated samples.
